// File: rtl/collision_detector.sv
// collision_detector: accumulates per-frame sprite overlaps (torpedo/asteroid/ship) and reports hits and score.
// Latency: pixel -> accumulator 2 cycles; hit pulses and score update are visible 2 cycles after vsync.
// Backpressure: none; one pixel is consumed every clock and outputs are frame-synchronous pulses.
module collision_detector #(
  parameter int TORPEDOS     = 2,
  parameter int ASTEROIDS    = 8,
  parameter int GRACE_FRAMES = 120,
  parameter int SCORE_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_vsync,
  input  logic                 i_pxl_valid,
  input  logic                 i_ship_draw,
  input  logic [TORPEDOS-1:0]  i_torpedo_draw,
  input  logic [TORPEDOS-1:0]  i_torpedo_live,
  input  logic [ASTEROIDS-1:0] i_asteroid_draw,
  output logic [TORPEDOS-1:0]  o_torpedo_hit,
  output logic [ASTEROIDS-1:0] o_asteroid_hit,
  output logic                 o_ship_hit,
  output logic                 o_ship_invuln,
  output logic [SCORE_W-1:0]   o_score
);

  localparam int CNT_W = $clog2(ASTEROIDS + 1);
  localparam int GR_W  = $clog2(GRACE_FRAMES + 1);
  localparam int SUM_W = SCORE_W + CNT_W;

  typedef enum logic {S_SYNC = 1'b0, S_RUN = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_run;

  logic [TORPEDOS-1:0]  r_d_torp;
  logic [ASTEROIDS-1:0] r_d_ast;
  logic                 r_d_ship;
  logic                 r_commit;

  logic [TORPEDOS-1:0]  r_th_acc;
  logic [ASTEROIDS-1:0] r_ah_acc;
  logic                 r_sh_acc;
  logic [GR_W-1:0]      r_grace;

  logic [TORPEDOS-1:0]  w_th;
  logic [TORPEDOS-1:0]  w_th_frame;
  logic [ASTEROIDS-1:0] w_ah;
  logic [ASTEROIDS-1:0] w_ah_frame;
  logic                 w_sh;
  logic                 w_sh_frame;
  logic                 w_ship_hit;
  logic [CNT_W-1:0]     w_pop;
  logic [SUM_W-1:0]     w_sum;
  logic [SCORE_W-1:0]   w_score_nxt;

  // State register: SYNC after reset until the first frame boundary is seen.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_SYNC;
    else         r_state <= w_state_nxt;
  end

  // Next state: SYNC waits for vsync; RUN is terminal until reset.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      S_SYNC: if (i_vsync) w_state_nxt = S_RUN;
      S_RUN:  w_run = 1'b1;
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // Stage 1: register qualified draws; pixels seen in SYNC belong to a partial frame and are dropped.
  // r_commit marks the cycle after a vsync seen in RUN, so the synchronising vsync never commits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_d_torp <= '0;
      r_d_ast  <= '0;
      r_d_ship <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_d_torp <= i_torpedo_draw & i_torpedo_live & {TORPEDOS{i_pxl_valid & w_run}};
      r_d_ast  <= i_asteroid_draw & {ASTEROIDS{i_pxl_valid & w_run}};
      r_d_ship <= i_ship_draw & i_pxl_valid & w_run;
      r_commit <= i_vsync & w_run;
    end
  end

  // Stage 2 overlap terms; torpedo-ship and asteroid-asteroid pairs are deliberately not tested.
  assign w_th = r_d_torp & {TORPEDOS{|r_d_ast}};
  assign w_ah = r_d_ast & {ASTEROIDS{|r_d_torp}};
  assign w_sh = r_d_ship & (|r_d_ast);

  // Frame view includes the pixel still in stage 2, so the commit cycle flushes the pipeline.
  assign w_th_frame    = r_th_acc | w_th;
  assign w_ah_frame    = r_ah_acc | w_ah;
  assign w_sh_frame    = r_sh_acc | w_sh;
  assign w_ship_hit    = w_sh_frame & (r_grace == '0);
  assign o_ship_invuln = (r_grace != '0);

  // Score update: one point per distinct asteroid hit this frame, saturating at all-ones.
  always_comb begin
    w_pop = '0;
    for (int j = 0; j < ASTEROIDS; j++) begin
      w_pop = w_pop + CNT_W'(w_ah_frame[j]);
    end
    w_sum       = {{CNT_W{1'b0}}, o_score} + {{SCORE_W{1'b0}}, w_pop};
    w_score_nxt = (w_sum[SUM_W-1:SCORE_W] != '0) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
  end

  // Sticky-OR accumulation, and the per-frame commit of pulses, grace counter and score.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_th_acc       <= '0;
      r_ah_acc       <= '0;
      r_sh_acc       <= 1'b0;
      o_torpedo_hit  <= '0;
      o_asteroid_hit <= '0;
      o_ship_hit     <= 1'b0;
      o_score        <= '0;
      r_grace        <= GR_W'(GRACE_FRAMES);
    end else begin
      o_torpedo_hit  <= '0;
      o_asteroid_hit <= '0;
      o_ship_hit     <= 1'b0;
      if (r_commit) begin
        o_torpedo_hit  <= w_th_frame;
        o_asteroid_hit <= w_ah_frame;
        o_ship_hit     <= w_ship_hit;
        o_score        <= w_score_nxt;
        r_th_acc       <= '0;
        r_ah_acc       <= '0;
        r_sh_acc       <= 1'b0;
        if (w_ship_hit)           r_grace <= GR_W'(GRACE_FRAMES);
        else if (r_grace != '0)   r_grace <= r_grace - GR_W'(1);
      end else if (w_run) begin
        r_th_acc <= w_th_frame;
        r_ah_acc <= w_ah_frame;
        r_sh_acc <= w_sh_frame;
      end else begin
        r_th_acc <= '0;
        r_ah_acc <= '0;
        r_sh_acc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: randomized and directed checks of collision_detector against a frame-level model.
// Latency: expects hit pulses exactly two cycles after vsync, zero on the neighbouring cycles.
// Backpressure: none; the bench drives one pixel per clock.
module tb_collision_detector;
  localparam int T  = 2;
  localparam int A  = 8;
  localparam int G  = 120;
  localparam int SW = 16;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, vsync, pxl_valid, ship_draw;
  logic [T-1:0] torpedo_draw, torpedo_live, torpedo_hit;
  logic [A-1:0] asteroid_draw, asteroid_hit;
  logic         ship_hit, ship_invuln;
  logic [SW-1:0] score;

  collision_detector #(.TORPEDOS(T), .ASTEROIDS(A), .GRACE_FRAMES(G), .SCORE_W(SW)) dut (
    .i_clk(clk), .i_reset(reset), .i_vsync(vsync), .i_pxl_valid(pxl_valid),
    .i_ship_draw(ship_draw), .i_torpedo_draw(torpedo_draw), .i_torpedo_live(torpedo_live),
    .i_asteroid_draw(asteroid_draw), .o_torpedo_hit(torpedo_hit), .o_asteroid_hit(asteroid_hit),
    .o_ship_hit(ship_hit), .o_ship_invuln(ship_invuln), .o_score(score)
  );

  // Narrow-score instance used to reach saturation quickly.
  logic         s_reset, s_vsync, s_pxl_valid, s_ship_draw;
  logic [T-1:0] s_torp_draw, s_torp_live, s_torp_hit;
  logic [A-1:0] s_ast_draw, s_ast_hit;
  logic         s_ship_hit, s_invuln;
  logic [3:0]   s_score;

  collision_detector #(.TORPEDOS(T), .ASTEROIDS(A), .GRACE_FRAMES(2), .SCORE_W(4)) dut_sat (
    .i_clk(clk), .i_reset(s_reset), .i_vsync(s_vsync), .i_pxl_valid(s_pxl_valid),
    .i_ship_draw(s_ship_draw), .i_torpedo_draw(s_torp_draw), .i_torpedo_live(s_torp_live),
    .i_asteroid_draw(s_ast_draw), .o_torpedo_hit(s_torp_hit), .o_asteroid_hit(s_ast_hit),
    .o_ship_hit(s_ship_hit), .o_ship_invuln(s_invuln), .o_score(s_score)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level reference model.
  bit         m_synced;
  int         m_grace, m_score;
  logic [T-1:0] m_th;
  logic [A-1:0] m_ah;
  bit         m_sh;
  logic [T-1:0] e_th;
  logic [A-1:0] e_ah;
  bit         e_sh, e_inv;
  int         e_score;

  // Captured DUT outputs at V+1, V+2, V+3.
  logic [T-1:0] c_th [3];
  logic [A-1:0] c_ah [3];
  logic         c_sh [3];
  logic [SW-1:0] c_score;
  logic         c_inv;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_synced = 0; m_grace = G; m_score = 0;
    m_th = '0; m_ah = '0; m_sh = 0;
  endtask

  task automatic model_pixel(input bit v, input bit s, input logic [T-1:0] t,
                             input logic [T-1:0] l, input logic [A-1:0] a);
    logic [T-1:0] te;
    te = t & l;
    if (m_synced && v) begin
      if (a != '0) m_th = m_th | te;
      if (te != '0) m_ah = m_ah | a;
      if (s && a != '0) m_sh = 1;
    end
  endtask

  task automatic model_commit();
    if (!m_synced) begin
      m_synced = 1; e_th = '0; e_ah = '0; e_sh = 0;
    end else begin
      e_th = m_th; e_ah = m_ah; e_sh = m_sh && (m_grace == 0);
      if (e_sh) m_grace = G;
      else if (m_grace > 0) m_grace = m_grace - 1;
      m_score = m_score + $countones(m_ah);
      if (m_score > SMAX) m_score = SMAX;
    end
    m_th = '0; m_ah = '0; m_sh = 0;
    e_score = m_score;
    e_inv = (m_grace != 0);
  endtask

  task automatic set_px(input bit v, input bit s, input logic [T-1:0] t,
                        input logic [T-1:0] l, input logic [A-1:0] a);
    pxl_valid = v; ship_draw = s; torpedo_draw = t; torpedo_live = l; asteroid_draw = a;
  endtask

  task automatic drive(input bit v, input bit s, input logic [T-1:0] t,
                       input logic [T-1:0] l, input logic [A-1:0] a);
    set_px(v, s, t, l, a);
    model_pixel(v, s, t, l, a);
    cyc();
  endtask

  task automatic do_reset(input bit with_vsync);
    reset = 1'b1; vsync = with_vsync;
    set_px(0, 0, '0, '0, '0);
    cyc();
    vsync = 1'b0;
    cyc();
    reset = 1'b0;
    model_reset();
  endtask

  // vsync cycle optionally carrying a pixel, then capture of the three following cycles.
  task automatic frame_end(input bit v, input bit s, input logic [T-1:0] t,
                           input logic [T-1:0] l, input logic [A-1:0] a);
    vsync = 1'b1;
    set_px(v, s, t, l, a);
    model_pixel(v, s, t, l, a);
    model_commit();
    cyc();
    vsync = 1'b0;
    set_px(0, 0, '0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      c_th[k] = torpedo_hit; c_ah[k] = asteroid_hit; c_sh[k] = ship_hit;
      if (k == 1) begin c_score = score; c_inv = ship_invuln; end
      if (k < 2) cyc();
    end
  endtask

  task automatic test_reset();
    do_reset(0);
    n_cmp++;
    if ({torpedo_hit, asteroid_hit, ship_hit} !== '0 || score !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got th=%b ah=%h sh=%b score=%0d, want 0/0/0/0",
               torpedo_hit, asteroid_hit, ship_hit, score);
    end
    n_cmp++;
    if (ship_invuln !== 1'b1) begin
      n_err++;
      $display("FAIL reset_invuln: got %b, want 1", ship_invuln);
    end
  endtask

  task automatic test_first_hit();
    do_reset(0);
    for (int i = 0; i < 9; i++) drive(0, 0, '0, '0, '0);
    frame_end(0, 0, '0, '0, '0);
    n_cmp++;
    if ({c_th[0], c_ah[0], c_sh[0], c_th[1], c_ah[1], c_sh[1], c_th[2], c_ah[2], c_sh[2]} !== '0
        || c_score !== '0) begin
      n_err++;
      $display("FAIL sync_vsync_quiet: got th=%b ah=%h score=%0d, want no pulses, score 0",
               c_th[1], c_ah[1], c_score);
    end
    drive(0, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++) drive(1, 0, 2'b01, 2'b11, 8'h08);
    drive(0, 0, '0, '0, '0);
    frame_end(0, 0, '0, '0, '0);
    n_cmp++;
    if (c_th[1] !== 2'b01 || c_ah[1] !== 8'h08 || c_sh[1] !== 1'b0) begin
      n_err++;
      $display("FAIL first_hit_pulse: got th=%b ah=%h sh=%b, want 01/08/0", c_th[1], c_ah[1], c_sh[1]);
    end
    n_cmp++;
    if ({c_th[0], c_ah[0], c_th[2], c_ah[2]} !== '0) begin
      n_err++;
      $display("FAIL first_hit_width: got V+1 th=%b ah=%h, V+3 th=%b ah=%h, want 0",
               c_th[0], c_ah[0], c_th[2], c_ah[2]);
    end
    n_cmp++;
    if (c_score !== 16'd1) begin
      n_err++;
      $display("FAIL first_hit_score: got %0d, want 1", c_score);
    end
  endtask

  task automatic test_multi_torp();
    do_reset(0);
    frame_end(0, 0, '0, '0, '0);
    drive(1, 0, 2'b01, 2'b11, 8'h20);
    drive(1, 0, 2'b10, 2'b11, 8'h20);
    drive(1, 0, 2'b11, 2'b11, 8'h20);
    frame_end(0, 0, '0, '0, '0);
    n_cmp++;
    if (c_th[1] !== 2'b11 || c_ah[1] !== 8'h20 || c_score !== 16'd1) begin
      n_err++;
      $display("FAIL multi_torp: got th=%b ah=%h score=%0d, want 11/20/1", c_th[1], c_ah[1], c_score);
    end
  endtask

  task automatic test_gating();
    do_reset(0);
    frame_end(0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) drive(0, 1, 2'b01, 2'b11, 8'h08);
    drive(1, 0, 2'b10, 2'b01, 8'h08);
    drive(1, 1, 2'b00, 2'b11, 8'h00);
    frame_end(0, 0, '0, '0, '0);
    n_cmp++;
    if (c_th[1] !== '0 || c_ah[1] !== '0 || c_sh[1] !== 1'b0 || c_score !== '0) begin
      n_err++;
      $display("FAIL gating: got th=%b ah=%h sh=%b score=%0d, want all 0",
               c_th[1], c_ah[1], c_sh[1], c_score);
    end
  endtask

  task automatic test_flush();
    do_reset(0);
    frame_end(0, 0, '0, '0, '0);
    drive(0, 0, '0, '0, '0);
    frame_end(1, 0, 2'b10, 2'b11, 8'h80);
    n_cmp++;
    if (c_th[1] !== 2'b10 || c_ah[1] !== 8'h80 || c_score !== 16'd1) begin
      n_err++;
      $display("FAIL vsync_pixel_flush: got th=%b ah=%h score=%0d, want 10/80/1",
               c_th[1], c_ah[1], c_score);
    end
  endtask

  task automatic test_ship_grace();
    do_reset(0);
    frame_end(0, 0, '0, '0, '0);
    for (int f = 1; f <= G; f++) begin
      if (f <= 3) drive(1, 1, '0, '0, 8'h01);
      frame_end(0, 0, '0, '0, '0);
      if (f <= 3) begin
        n_cmp++;
        if (c_sh[1] !== 1'b0 || c_inv !== 1'b1) begin
          n_err++;
          $display("FAIL grace_early f=%0d: got sh=%b inv=%b, want 0/1", f, c_sh[1], c_inv);
        end
      end
      if (f >= G - 1) begin
        n_cmp++;
        if (c_inv !== (f == G - 1)) begin
          n_err++;
          $display("FAIL grace_expiry f=%0d: got inv=%b, want %b", f, c_inv, (f == G - 1));
        end
      end
    end
    drive(1, 1, '0, '0, 8'h40);
    frame_end(0, 0, '0, '0, '0);
    n_cmp++;
    if (c_sh[0] !== 1'b0 || c_sh[1] !== 1'b1 || c_sh[2] !== 1'b0 || c_inv !== 1'b1) begin
      n_err++;
      $display("FAIL ship_hit: got sh=%b%b%b inv=%b, want 010/1", c_sh[0], c_sh[1], c_sh[2], c_inv);
    end
  endtask

  task automatic test_random();
    do_reset(0);
    frame_end(0, 0, '0, '0, '0);
    for (int f = 0; f < 160; f++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int p = 0; p < n; p++)
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, T'($urandom), T'($urandom),
              A'($urandom & $urandom & $urandom));
      if ($urandom_range(0, 4) == 0)
        frame_end(1, 1, T'($urandom), 2'b11, A'($urandom & $urandom));
      else
        frame_end(0, 0, '0, '0, '0);
      n_cmp++;
      if (c_th[1] !== e_th || c_ah[1] !== e_ah || c_sh[1] !== e_sh ||
          c_score !== SW'(e_score) || c_inv !== e_inv) begin
        n_err++;
        $display("FAIL random f=%0d: got th=%b ah=%h sh=%b score=%0d inv=%b, want th=%b ah=%h sh=%b score=%0d inv=%b",
                 f, c_th[1], c_ah[1], c_sh[1], c_score, c_inv, e_th, e_ah, e_sh, e_score, e_inv);
      end
      n_cmp++;
      if ({c_th[0], c_ah[0], c_sh[0], c_th[2], c_ah[2], c_sh[2]} !== '0) begin
        n_err++;
        $display("FAIL random_width f=%0d: got pulses outside V+2", f);
      end
    end
  endtask

  task automatic test_midframe_reset();
    do_reset(0);
    frame_end(0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) drive(1, 1, 2'b11, 2'b11, 8'hFF);
    do_reset(1);
    for (int v = 0; v < 2; v++) begin
      drive(0, 0, '0, '0, '0);
      frame_end(0, 0, '0, '0, '0);
      n_cmp++;
      if ({c_th[1], c_ah[1], c_sh[1]} !== '0 || c_score !== '0 || c_inv !== 1'b1) begin
        n_err++;
        $display("FAIL midframe_reset v=%0d: got th=%b ah=%h sh=%b score=%0d inv=%b, want 0/0/0/0/1",
                 v, c_th[1], c_ah[1], c_sh[1], c_score, c_inv);
      end
    end
  endtask

  task automatic sat_frame(input logic [A-1:0] a);
    s_pxl_valid = 1'b1; s_torp_draw = 2'b01; s_ast_draw = a;
    cyc();
    s_pxl_valid = 1'b0; s_torp_draw = '0; s_ast_draw = '0; s_vsync = 1'b1;
    cyc();
    s_vsync = 1'b0;
    cyc();
  endtask

  task automatic test_saturation();
    s_reset = 1'b1;
    cyc(); cyc();
    s_reset = 1'b0;
    sat_frame(8'h00);
    sat_frame(8'h7F);
    sat_frame(8'h7F);
    n_cmp++;
    if (s_score !== 4'd14) begin
      n_err++;
      $display("FAIL sat_preload: got %0d, want 14", s_score);
    end
    sat_frame(8'h07);
    n_cmp++;
    if (s_score !== 4'd15 || s_ast_hit !== 8'h07) begin
      n_err++;
      $display("FAIL sat_clip: got score=%0d ah=%h, want 15/07", s_score, s_ast_hit);
    end
    sat_frame(8'hFF);
    n_cmp++;
    if (s_score !== 4'd15) begin
      n_err++;
      $display("FAIL sat_nowrap: got %0d, want 15", s_score);
    end
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0;
    set_px(0, 0, '0, '0, '0);
    s_reset = 1'b1; s_vsync = 1'b0; s_pxl_valid = 1'b0; s_ship_draw = 1'b0;
    s_torp_draw = '0; s_torp_live = 2'b11; s_ast_draw = '0;
    model_reset();
    test_reset();
    test_first_hit();
    test_multi_torp();
    test_gating();
    test_flush();
    test_ship_grace();
    test_random();
    test_midframe_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Pixel-level collision detector. Sits directly downstream of the torpedo, ship and asteroid sprite units.
- Each frame it consumes their per-pixel Draw outputs and accumulates overlaps. At each vsync it emits one-cycle hit pulses and updates a score.
- torpedo_hit[i] feeds the collision input of torpedo unit i. asteroid_hit and ship_hit feed the asteroid field and ship control.

Parameters:
- TORPEDOS, 2, number of torpedo draw/hit channels.
- ASTEROIDS, 8, number of asteroid draw/hit channels.
- GRACE_FRAMES, 120, frames of ship invulnerability after reset or after a ship hit (2 s at 60 Hz).
- SCORE_W, 16, score counter width.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  frame-boundary pulse, one cycle wide, asserted during blanking.
- pxl_valid  in  1  high during active video; draws are ignored when low.
- ship_draw  in  1  ship sprite covers current pixel.
- torpedo_draw  in  TORPEDOS  per-torpedo Draw (already gated by t_fire).
- torpedo_live  in  TORPEDOS  per-torpedo t_fire (torpedo flying).
- asteroid_draw  in  ASTEROIDS  per-asteroid Draw.
- torpedo_hit  out  TORPEDOS  one-cycle pulse: torpedo i hit an asteroid last frame.
- asteroid_hit  out  ASTEROIDS  one-cycle pulse: asteroid j was hit by any torpedo last frame.
- ship_hit  out  1  one-cycle pulse: ship overlapped an asteroid last frame while vulnerable.
- ship_invuln  out  1  level signal; high while the grace counter is nonzero.
- score  out  SCORE_W  running count of asteroid hits, saturating.

Behaviour:
- Reset (sync, active-high):
  - all hit outputs 0; score 0; grace counter = GRACE_FRAMES, so ship_invuln = 1.
  - accumulators cleared; FSM enters SYNC.
- FSM states:
  - SYNC: discards pixels, because a partial frame may follow reset. vsync -> RUN. No commit happens on this vsync; outputs stay 0.
  - RUN: accumulate pixels; each vsync triggers a commit. Remains in RUN.
- Pipeline stage 1, cycle T: register all draw inputs ANDed with pxl_valid. torpedo_draw[i] is additionally ANDed with torpedo_live[i].
- Pipeline stage 2, cycle T+1: compute overlap terms and OR them into the frame accumulators.
  - th[i] = d_torp[i] & |d_ast
  - ah[j] = d_ast[j] & |d_torp
  - sh = d_ship & |d_ast
  - Torpedo-ship and asteroid-asteroid overlaps are ignored.
- Commit:
  - vsync is delayed one cycle (vsync_d). On the cycle vsync_d = 1 in RUN, output registers load (accumulator OR current stage-2 term). This flushes any pixel still in the pipeline into the closing frame.
  - Accumulators clear on the same edge. Pulses are visible on cycle V+2 (V = vsync cycle), for exactly one cycle.
- Ship grace:
  - ship_hit = sh_acc & (grace == 0).
  - When ship_hit fires, grace reloads to GRACE_FRAMES.
  - Otherwise, at each commit, a nonzero grace decrements by 1.
  - ship_invuln = (grace != 0).
- Score:
  - At commit, score += popcount(asteroid_hit next value). Adds 0..ASTEROIDS per frame.
  - Saturates at 2^SCORE_W-1 and never wraps.
  - A single asteroid hit by several torpedoes in one frame counts once. Every involved torpedo gets its own hit pulse.
- Simultaneous events:
  - vsync and reset in the same cycle: reset wins, and the state is SYNC.
  - Overlap pixels arriving on the vsync_d cycle belong to the closing frame.
  - A new pixel sampled in the vsync_d cycle belongs to the next frame. It cannot occur in practice because pxl_valid = 0 during blanking.
- Reset mid-frame: all accumulated overlaps are lost. The first reported frame is the first complete frame after reset.
- Multiple hits on one object within a frame produce one pulse only; accumulators are sticky ORs.

Test Plan:
- Reset, then vsync at cycle 10, then torpedo_draw[0] & asteroid_draw[3] overlap for 4 pixels, vsync at V -> torpedo_hit = 2'b01 and asteroid_hit = 8'h08 on cycle V+2 only; score = 1. The first vsync produces no pulses.
- Torpedo 0 and torpedo 1 both overlap asteroid 5 in one frame -> torpedo_hit = 2'b11, asteroid_hit = 8'h20, score increments by 1 only.
- Ship overlaps an asteroid in frame 3 after reset (grace = 120) -> no ship_hit, ship_invuln = 1. After 120 commits ship_invuln = 0; overlap then -> ship_hit pulse and ship_invuln back to 1.
- Overlap with pxl_valid = 0, or with torpedo_live[1] = 0 -> no pulses, score unchanged.
- Preload score to 16'hFFFE, hit 3 asteroids in one frame -> score = 16'hFFFF.
- Overlap pixels, then reset asserted mid-frame, then 2 vsyncs -> no pulses at either vsync; score = 0.
